// File: rtl/bank_ring_fifo_pkg.sv
// Shared definitions for the banked ring FIFO: derived geometry helpers and
// the per-cycle bank occupancy events.
package bank_ring_fifo_pkg;

   // Occupancy event encoded as {release, commit}.
   typedef enum logic [1:0] {
      BANK_HOLD  = 2'b00,
      BANK_FILL  = 2'b01,
      BANK_DRAIN = 2'b10,
      BANK_SWAP  = 2'b11
   } bank_evt_e;

   function automatic int bank_size(input int n, input int b);
      return 1 << (n - b);
   endfunction

   function automatic int off_width(input int n, input int b);
      return n - b;
   endfunction

endpackage

// File: rtl/bank_ring_fifo_ram.sv
// Word store for the banked ring FIFO: one synchronous write port and one
// asynchronous read port, contents never reset.
module bank_ring_fifo_ram
   import bank_ring_fifo_pkg::*;
#(
   parameter int W  = 16,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/bank_ring_fifo.sv
// Multi-bank FIFO passing whole banks from writer to reader, with partial-bank
// flush and per-bank recorded length. Optional abort: define FIFO_ABORT_EN.
module bank_ring_fifo
   import bank_ring_fifo_pkg::*;
#(
   parameter int W = 16,
   parameter int N = 8,
   parameter int B = 1
) (
   input  logic         clk,
   input  logic         rst_,
   input  logic         w_trigger,
   input  logic [W-1:0] w_data,
   input  logic         w_flush,
   input  logic         w_abort,
   output logic         w_done,
   output logic [B:0]   w_banks,
   input  logic         r_trigger,
   output logic [W-1:0] r_data,
   output logic         r_last,
   output logic         r_ready,
   output logic         r_done
);

   localparam int OW = off_width(N, B);
   localparam int NB = 2 ** B;
   localparam logic [B:0] CNT_FULL = {1'b1, {B{1'b0}}};
   localparam logic [B:0] CNT_ONE  = {{B{1'b0}}, 1'b1};

   logic [B-1:0]  wb_reg, rb_reg;
   logic [OW-1:0] wo_reg, ro_reg;
   logic [B:0]    cnt_reg, cnt_next;
   logic [OW-1:0] len_q [NB];
   logic [OW-1:0] len_next;
   logic          abort_active;
   logic          full, auto_commit, flush_commit, commit, release_bank;
   bank_evt_e     evt;

`ifdef FIFO_ABORT_EN
   assign abort_active = w_abort;
`else
   logic unused_abort;
   assign unused_abort = w_abort;
   assign abort_active = 1'b0;
`endif

   assign full   = (cnt_reg == CNT_FULL);
   assign w_done = w_trigger && !full && !abort_active;

   // A flush counts the word being accepted this cycle, so it can close the
   // bank in the same cycle as an auto commit without committing twice.
   assign auto_commit  = w_done && (&wo_reg);
   assign flush_commit = w_flush && !abort_active && ((wo_reg != '0) || w_done);
   assign commit       = auto_commit || flush_commit;
   assign len_next     = w_done ? wo_reg : (wo_reg - OW'(1));

   assign r_ready      = (cnt_reg != '0);
   assign r_done       = r_trigger && r_ready;
   assign r_last       = r_ready && (ro_reg == len_q[rb_reg]);
   assign release_bank = r_done && r_last;
   assign w_banks      = cnt_reg;

   assign evt = bank_evt_e'({release_bank, commit});

   always_comb begin
      cnt_next = cnt_reg;
      case (evt)
         BANK_FILL:  cnt_next = cnt_reg + CNT_ONE;
         BANK_DRAIN: cnt_next = cnt_reg - CNT_ONE;
         default:    cnt_next = cnt_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         wb_reg  <= '0;
         wo_reg  <= '0;
         rb_reg  <= '0;
         ro_reg  <= '0;
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
         if (abort_active) begin
            wo_reg <= '0;
         end else if (commit) begin
            wb_reg <= wb_reg + B'(1);
            wo_reg <= '0;
         end else if (w_done) begin
            wo_reg <= wo_reg + OW'(1);
         end
         if (r_done) begin
            if (r_last) begin
               rb_reg <= rb_reg + B'(1);
               ro_reg <= '0;
            end else begin
               ro_reg <= ro_reg + OW'(1);
            end
         end
      end
   end

   // Length registers hold (word count - 1); not reset, only read once committed.
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_len
         logic [OW-1:0] len_bank_reg;
         always_ff @(posedge clk) begin
            if (commit && (wb_reg == B'(gi))) begin
               len_bank_reg <= len_next;
            end
         end
         assign len_q[gi] = len_bank_reg;
      end
   endgenerate

   bank_ring_fifo_ram #(
      .W  (W),
      .AW (N)
   ) u_ram (
      .clk   (clk),
      .we    (w_done),
      .waddr ({wb_reg, wo_reg}),
      .wdata (w_data),
      .raddr ({rb_reg, ro_reg}),
      .rdata (r_data)
   );

endmodule
